// File: rtl/cpu_defs.sv
// Shared pipeline definitions used by fetch, decode and the hazard unit.
//   NOP_INSTR / SYSCALL_INSTR : canonical instruction words
//   fetch_state_t             : fetch FSM states
//   if_id_t                   : IF/ID pipeline register payload
package cpu_defs;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;

  typedef enum logic {RUN, HALTED} fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush controls.
//   clk, rst : clock, synchronous active-high reset (clears to a bubble at pc 0)
//   hold     : keep every field (highest priority after rst)
//   flush    : load a bubble; instr forced to NOP, pc fields keep their value
//   d / q    : payload in / registered payload out
module if_id_reg
  import cpu_defs::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
    end else if (hold) begin
      q <= q;
    end else if (flush) begin
      // bubble: zero the instruction so nothing downstream sees stale bits
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory address,
// captures the fetched word into IF/ID, handles stall, redirect and halt.
//   clk, rst            : clock, synchronous active-high reset
//   stall               : hazard hold; freezes pc and IF/ID
//   redirect_valid/target : taken branch / jump from ID
//   imem_addr / imem_data : instruction memory address out, word back (comb.)
//   id_instr, id_pc, id_pc_plus4, id_valid : IF/ID contents
//   halted              : fetch stopped on HALT_INSTR
//   misalign_err        : sticky, a redirect target was not word aligned
//   fetch_count         : saturating count of valid instructions delivered
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = SYSCALL_INSTR,
  parameter int          COUNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc_plus4,
  output logic               id_valid,
  output logic               halted,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] fetch_count
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         run, advance, take_redirect, load, halt_hit;
  if_id_t       ifid_d, ifid_q;

  assign run           = (state == RUN);
  assign advance       = run & ~stall;
  assign take_redirect = advance & redirect_valid;
  // a redirect squashes this cycle's fetch, including a wrong-path halt
  assign load          = advance & ~redirect_valid;
  assign halt_hit      = load & (imem_data == HALT_INSTR);

  assign imem_addr = pc;

  assign ifid_d = '{instr: imem_data, pc: pc, pc_plus4: pc + 32'd4, valid: 1'b1};

  // once halted, every unstalled cycle feeds a bubble into decode
  if_id_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .flush (~run | redirect_valid),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign id_instr    = ifid_q.instr;
  assign id_pc       = ifid_q.pc;
  assign id_pc_plus4 = ifid_q.pc_plus4;
  assign id_valid    = ifid_q.valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pc           <= RESET_PC;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      if (take_redirect) begin
        pc <= {redirect_target[31:2], 2'b00};
        if (redirect_target[1:0] != 2'b00) misalign_err <= 1'b1;
      end else if (load && !halt_hit) begin
        pc <= pc + 32'd4;
      end
      if (halt_hit) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
      if (load && fetch_count != {COUNT_W{1'b1}})
        fetch_count <= fetch_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural fetch model is checked against
// the DUT on every falling edge, plus literal expectations along the script.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_target, imem_addr, imem_data;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        id_valid, halted, misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [1024];
  int tests = 0, fails = 0;
  bit chk_en = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_idpc, m_idp4, m_cnt, w;
  logic        m_valid, m_halt, m_mis;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid), .halted(halted), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[11:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one fetch step per rising edge, straight from the rules.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_instr = 0; m_idpc = 0; m_idp4 = 0; m_valid = 0;
      m_halt = 0; m_mis = 0; m_cnt = 0;
    end else if (m_halt) begin
      if (!stall) begin m_instr = 0; m_valid = 0; end
    end else if (stall) begin
      // everything holds
    end else if (redirect_valid) begin
      m_pc = redirect_target & 32'hFFFF_FFFC;
      m_instr = 0; m_valid = 0;
      if (redirect_target % 4 != 0) m_mis = 1;
    end else begin
      w = mem[(m_pc / 4) % 1024];
      m_instr = w; m_idpc = m_pc; m_idp4 = m_pc + 4; m_valid = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (w == 32'h0000_000C) m_halt = 1;
      else m_pc = m_pc + 4;
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("m.imem_addr", imem_addr, m_pc);
    check("m.id_instr", id_instr, m_instr);
    check("m.id_pc", id_pc, m_idpc);
    check("m.id_pc_plus4", id_pc_plus4, m_idp4);
    check("m.id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    check("m.halted", {31'b0, halted}, {31'b0, m_halt});
    check("m.misalign", {31'b0, misalign_err}, {31'b0, m_mis});
    check("m.count", fetch_count, m_cnt);
  end

  task automatic edge_drive();  // wait for edge, then drive safely after it
    @(posedge clk); #2;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".addr"}, imem_addr, 32'h0);
    check({tag, ".instr"}, id_instr, 32'h0);
    check({tag, ".pc"}, id_pc, 32'h0);
    check({tag, ".pc4"}, id_pc_plus4, 32'h0);
    check({tag, ".valid"}, {31'b0, id_valid}, 32'h0);
    check({tag, ".halted"}, {31'b0, halted}, 32'h0);
    check({tag, ".mis"}, {31'b0, misalign_err}, 32'h0);
    check({tag, ".cnt"}, fetch_count, 32'h0);
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h2008_0001; prog[1] = 32'h2009_0002;
    prog[2] = 32'h0109_5020; prog[3] = 32'h0000_000C;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 | i;
    for (int i = 0; i < 4; i++) mem[i] = prog[i];
    rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
    @(posedge clk); @(negedge clk);
    check_reset("reset");
    chk_en = 1;

    // T1: straight-line fetch into halt
    edge_drive(); rst = 0;
    @(negedge clk); check("t1.addr0", imem_addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1.instr", id_instr, prog[k]);
      check("t1.idpc", id_pc, 4 * k);
      check("t1.addr", imem_addr, (k < 3) ? 4 * k + 4 : 12);
    end
    check("t1.halted", {31'b0, halted}, 32'h1);
    @(negedge clk);
    check("t1.bubble", {31'b0, id_valid}, 32'h0);
    check("t1.addr_frozen", imem_addr, 32'd12);
    check("t1.count", fetch_count, 32'd4);

    // T2: 3-cycle stall at pc=8
    edge_drive(); rst = 1; mem[3] = 32'h2000_0003;
    edge_drive(); rst = 0;
    @(posedge clk); edge_drive(); stall = 1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("t2.addr", imem_addr, 32'd8);
      check("t2.idpc", id_pc, 32'd4);
      check("t2.valid", {31'b0, id_valid}, 32'h1);
      check("t2.count", fetch_count, 32'd2);
    end
    stall = 0;
    @(negedge clk); check("t2.release", id_pc, 32'd8);

    // T3: redirect to 0x40 while pc=0x10
    edge_drive(); redirect_valid = 1; redirect_target = 32'h40;
    check("t3.pc_before", imem_addr, 32'h10);
    edge_drive(); redirect_valid = 0;
    @(negedge clk);
    check("t3.valid", {31'b0, id_valid}, 32'h0);
    check("t3.instr", id_instr, 32'h0);
    check("t3.addr", imem_addr, 32'h40);
    @(negedge clk); check("t3.idpc", id_pc, 32'h40);

    // T4: stall masks redirect; redirect re-presented
    stall = 1; redirect_valid = 1; redirect_target = 32'h80;
    edge_drive(); stall = 0;
    @(negedge clk); check("t4.held", imem_addr, 32'h44);
    edge_drive(); redirect_valid = 0;
    @(negedge clk); check("t4.taken", imem_addr, 32'h80);

    // T5: misaligned target, sticky
    redirect_valid = 1; redirect_target = 32'h43;
    edge_drive(); redirect_valid = 0;
    @(negedge clk);
    check("t5.addr", imem_addr, 32'h40);
    check("t5.mis", {31'b0, misalign_err}, 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5.sticky", {31'b0, misalign_err}, 32'h1);
    check("t5.addr2", imem_addr, 32'h4C);

    // T6: reset beats stall+redirect; then pc wrap
    rst = 1; stall = 1; redirect_valid = 1; redirect_target = 32'h100;
    edge_drive(); rst = 0; stall = 0; redirect_valid = 0;
    @(negedge clk); check_reset("t6");
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    edge_drive(); redirect_valid = 0;
    @(negedge clk); check("t6.top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("t6.wrap", imem_addr, 32'h0);
    check("t6.idpc", id_pc, 32'hFFFF_FFFC);
    check("t6.pc4", id_pc_plus4, 32'h0);

    // T7: redirect beats halt on imem_data; then halt under stall
    mem[3] = 32'h0000_000C;
    @(posedge clk); @(posedge clk); edge_drive();
    check("t7.at12", imem_addr, 32'd12);
    redirect_valid = 1; redirect_target = 32'h20;
    edge_drive(); redirect_valid = 0;
    @(negedge clk);
    check("t7.nohalt", {31'b0, halted}, 32'h0);
    check("t7.addr", imem_addr, 32'h20);
    redirect_valid = 1; redirect_target = 32'hC;
    edge_drive(); redirect_valid = 0;
    edge_drive(); stall = 1;
    @(negedge clk);
    check("t7.halted", {31'b0, halted}, 32'h1);
    check("t7.hinstr", id_instr, 32'hC);
    @(posedge clk); @(negedge clk);
    check("t7.hold_instr", id_instr, 32'hC);
    check("t7.hold_valid", {31'b0, id_valid}, 32'h1);
    stall = 0; redirect_valid = 1; redirect_target = 32'h40;
    edge_drive(); redirect_valid = 0;
    @(negedge clk);
    check("t7.bubble", {31'b0, id_valid}, 32'h0);
    check("t7.frozen", imem_addr, 32'd12);
    check("t7.still", {31'b0, halted}, 32'h1);

    @(posedge clk); @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the instruction memory and feeding the decode stage.
- Owns the PC register and drives the instruction-memory address.
- Captures the combinational instruction word into the IF/ID pipeline register.
- Handles hazard stalls, branch/jump redirects from ID, and a halt-on-instruction stop condition.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
HALT_INSTR, 32'h0000_000C, instruction word (syscall) that stops fetching.
COUNT_W, 32, width of the fetched-instruction counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hazard-unit hold request; freezes PC and IF/ID.
redirect_valid  in  1  ID-stage branch taken / jump.
redirect_target  in  32  new PC for the redirect.
imem_addr  out  32  byte address to instruction memory (word index = addr[11:2]).
imem_data  in  32  instruction word returned combinationally for imem_addr.
id_instr  out  32  IF/ID instruction.
id_pc  out  32  IF/ID PC of id_instr.
id_pc_plus4  out  32  IF/ID id_pc+4.
id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
halted  out  1  fetch stopped by HALT_INSTR.
misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0.
fetch_count  out  COUNT_W  number of valid instructions delivered to IF/ID.

Behaviour:
- Reset (rst=1 at edge, overrides every other input):
  - pc=RESET_PC; state=RUN.
  - id_instr=32'h0, id_pc=0, id_pc_plus4=0, id_valid=0.
  - halted=0, misalign_err=0, fetch_count=0.
- imem_addr = pc, driven directly from the PC register. No combinational path from any input to imem_addr.
- Latency: an instruction fetched in cycle n appears on the id_* outputs after the edge ending cycle n.
- FSM states: RUN and HALTED. There is no exit from HALTED except rst.
- RUN, priority order (highest first):
  1. stall=1:
     - pc and all id_* registers hold.
     - fetch_count holds.
     - redirect_valid is ignored; the hazard unit re-presents it.
  2. redirect_valid=1:
     - pc <= {redirect_target[31:2],2'b00}.
     - id_instr <= 0, id_valid <= 0 (squashes the wrong-path fetch).
     - Other id_* fields hold.
     - If redirect_target[1:0] != 0, misalign_err <= 1 (sticky until rst).
  3. imem_data == HALT_INSTR:
     - Load IF/ID normally with the halt instruction (valid, counted).
     - pc holds; state <= HALTED; halted <= 1.
  4. Otherwise:
     - id_instr <= imem_data, id_pc <= pc, id_pc_plus4 <= pc+4, id_valid <= 1.
     - pc <= pc+4.
- HALTED:
  - pc frozen.
  - While stall=1, IF/ID holds, so the halt instruction stays in decode.
  - When stall=0, IF/ID loads a bubble (id_instr=0, id_valid=0).
  - redirect_valid ignored; halted stays 1.
- Arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
  - fetch_count increments when id_valid is loaded with 1 and saturates at all-ones.
- A redirect in the same cycle as HALT_INSTR on imem_data: redirect wins and no halt occurs (wrong-path halt).
- No X propagation: id_instr is forced to 0 on every bubble.

Decomposition:
- Shared package cpu_defs:
  - NOP_INSTR (32'h0) and SYSCALL_INSTR (32'h0000_000C).
  - fetch_state_t enum {RUN, HALTED}.
  - Shared with decode and the hazard unit.
- One sub-module, if_id_reg:
  - Registers instr/pc/pc_plus4/valid with hold (stall) and flush (bubble) controls.
  - Reused by later pipeline registers.
- PC logic, FSM and counter stay in fetch_unit.

Test Plan:
1. Reset, memory words 0..3 = 0x20080001,0x20090002,0x01095020,0x0000000C, no stall/redirect:
   - imem_addr steps 0,4,8,12.
   - id_instr matches words in order with id_pc 0,4,8,12.
   - halted=1 after the edge at pc=12; imem_addr stays 12; next cycle id_valid=0; fetch_count=4.
2. stall=1 for 3 cycles at pc=8 (id_pc=4):
   - imem_addr stays 8; id_* hold (id_pc=4, id_valid=1); fetch_count unchanged.
   - After release, id_pc=8 next edge.
3. redirect_valid=1, target 0x40 while IF holds pc=0x10:
   - Next edge: id_valid=0, id_instr=0, imem_addr=0x40.
   - Following edge: id_pc=0x40.
4. stall=1 and redirect_valid=1 together, then redirect re-presented with stall=0:
   - First cycle: pc unchanged.
   - Second cycle: pc=target.
5. Redirect target 0x43:
   - imem_addr=0x40; misalign_err=1, and it stays 1 through further fetches until rst.
6. rst asserted mid-run with stall=1 and redirect_valid=1; separately, pc forced via redirect to 0xFFFF_FFFC:
   - With rst: all outputs return to reset values on that edge.
   - From 0xFFFF_FFFC: next pc=0x0000_0000.
